// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default widths and counter sizing.
package apb_pkg;

  localparam int unsigned ApbAddrWidth = 8;
  localparam int unsigned ApbDataWidth = 32;
  localparam int unsigned ApbTimeout   = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10
  } apb_state_e;

  // Bits needed to hold any value in 0..limit; never less than one bit.
  function automatic int unsigned apb_cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter. Counts cycles with enable high, saturating at the
// programmed limit, and flags the cycle whose wait would bring it to that limit.
module apb_wait_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] timeout,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   count_inc;

  assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

  // Next count: clear wins, otherwise step once per wait cycle up to the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q < timeout)) begin
      count_d = count_inc[WIDTH-1:0];
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit disables expiry altogether.
  assign expired = enable && (timeout != '0) && (count_inc >= {1'b0, timeout});

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one local command in IDLE, runs the
// SETUP/ACCESS handshake, and reports completion or timeout with a one-cycle pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ApbAddrWidth,
  parameter int unsigned DATA_WIDTH = ApbDataWidth,
  parameter int unsigned TIMEOUT    = ApbTimeout
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // Local command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // Local response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB side
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int unsigned CntW = apb_cnt_width(TIMEOUT);

  apb_state_e state_q, state_d;

  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic psel, penable, ready;
  logic timer_clear, timer_en, timer_expired;

  // Counter starts from zero on the first ACCESS cycle and only counts stalls.
  assign timer_clear = (state_q == StSetup);
  assign timer_en    = (state_q == StAccess) && !PREADY;

  apb_wait_timer #(
    .WIDTH (CntW)
  ) u_wait_timer (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .clear   (timer_clear),
    .enable  (timer_en),
    .timeout (CntW'(TIMEOUT)),
    .expired (timer_expired)
  );

  // Next-state, captured request fields, response and APB strobes.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel        = 1'b0;
    penable     = 1'b0;
    ready       = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = StSetup;
        end
      end

      StSetup: begin
        psel    = 1'b1;
        state_d = StAccess;
      end

      StAccess: begin
        psel    = 1'b1;
        penable = 1'b1;
        // PREADY beats a timeout landing in the same cycle.
        if (PREADY) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (timer_expired) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end

      default: begin
        // Unreachable encoding: recover to IDLE with everything cleared.
        state_d     = StIdle;
        pwrite_d    = 1'b0;
        paddr_d     = '0;
        pwdata_d    = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= StIdle;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = ready;
  assign PSEL      = psel;
  assign PENABLE   = penable;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level model plus a simple APB slave memory.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PRDATA = '0;

  logic          cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [AW-1:0] PADDR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave memory, written from the APB pins when a write handshake completes.
  logic [DW-1:0] slave_mem [2**AW];
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE) slave_mem[PADDR] <= PWDATA;
  end

  // Transaction-level reference model. m_k counts cycles since acceptance:
  // 1 is the setup cycle, 2..m_acc+1 are access cycles, then the response.
  int            plan_waits = 0;
  logic          m_init = 1'b0, m_active = 1'b0, m_rsp = 1'b0, m_err = 1'b0;
  logic          m_timeout = 1'b0, m_wr = 1'b0;
  int            m_k = 0, m_acc = 0, m_waits = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [DW-1:0] model_mem [2**AW];

  always @(posedge PCLK) begin
    if (PRESET) begin
      m_init   <= 1'b1;
      m_active <= 1'b0;
      m_rsp    <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
      m_addr   <= '0;
      m_wr     <= 1'b0;
      m_wdata  <= '0;
      m_k      <= 0;
    end else begin
      m_rsp <= 1'b0;
      if (!m_active) begin
        if (cmd_valid) begin
          m_active  <= 1'b1;
          m_k       <= 1;
          m_wr      <= cmd_write;
          m_addr    <= cmd_addr;
          m_wdata   <= cmd_wdata;
          m_waits   <= plan_waits;
          m_timeout <= (plan_waits >= TO);
          m_acc     <= (plan_waits >= TO) ? TO : plan_waits + 1;
        end
      end else if (m_k == m_acc + 1) begin
        m_active <= 1'b0;
        m_rsp    <= 1'b1;
        m_err    <= m_timeout;
        if (m_timeout) begin
          m_rdata <= '0;
        end else if (m_wr) begin
          m_rdata             <= '0;
          model_mem[m_addr]   <= m_wdata;
        end else begin
          m_rdata <= model_mem[m_addr];
        end
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge PCLK) begin
    if (m_init) begin
      chk("cmd_ready", cmd_ready, !m_active);
      chk("PSEL", PSEL, m_active);
      chk("PENABLE", PENABLE, m_active && (m_k >= 2));
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("PADDR", PADDR, m_addr);
      chk("PWRITE", PWRITE, m_wr);
      chk("PWDATA", PWDATA, m_wdata);
    end
  end

  // Advance one cycle, then drive the slave: PREADY rises after the planned
  // number of wait cycles; outside ACCESS both slave inputs carry noise.
  task automatic step();
    @(posedge PCLK);
    #1;
    if (m_active && (m_k >= 2)) begin
      PREADY = (m_k == m_waits + 2);
      PRDATA = PREADY ? slave_mem[PADDR] : $urandom;
    end else begin
      PREADY = 1'($urandom_range(0, 1));
      PRDATA = $urandom;
    end
  endtask

  // Issue one command and return the cycles from acceptance to rsp_valid.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int waits, output int lat);
    int guard;
    guard = 0;
    while (m_active && guard < 40) begin
      step();
      guard++;
    end
    checks++;
    if (m_active) begin
      errors++;
      $display("FAIL idle_wait: model still busy after %0d cycles", guard);
    end
    plan_waits = waits;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = addr;
    cmd_wdata  = data;
    step();
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      // Noise on the command port while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      step();
      lat++;
    end
    cmd_valid = 1'b0;
    chk("rsp_seen", rsp_valid, 1'b1);
  endtask

  logic [AW-1:0] written [$];

  initial begin
    int lat;
    int r;
    logic          wr;
    logic [AW-1:0] addr;
    int            waits;

    repeat (3) step();
    PRESET = 1'b0;
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_psel", PSEL, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    step();

    // Zero-wait write and read-back.
    do_txn(1'b1, 8'h10, 32'hDEADBEEF, 0, lat);
    chk("wr0_latency", lat, 3);
    chk("wr0_err", rsp_err, 1'b0);
    chk("wr0_slave_mem", slave_mem[8'h10], 32'hDEADBEEF);
    written.push_back(8'h10);
    step();
    do_txn(1'b0, 8'h10, 32'h0, 0, lat);
    chk("rd0_latency", lat, 3);
    chk("rd0_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd0_err", rsp_err, 1'b0);

    // Four wait states.
    do_txn(1'b1, 8'h24, 32'h12345678, 4, lat);
    chk("wait4_latency", lat, 7);
    written.push_back(8'h24);

    // Timeout: 16 stalled access cycles.
    do_txn(1'b0, 8'h44, 32'h0, 20, lat);
    chk("timeout_latency", lat, 18);
    chk("timeout_err", rsp_err, 1'b1);
    chk("timeout_rdata", rsp_rdata, 32'h0);

    // PREADY on the 16th access cycle wins over the timeout.
    do_txn(1'b0, 8'h10, 32'h0, 15, lat);
    chk("tie_latency", lat, 18);
    chk("tie_err", rsp_err, 1'b0);
    chk("tie_rdata", rsp_rdata, 32'hDEADBEEF);

    // Reset in the second ACCESS cycle aborts with no response.
    plan_waits = 8;
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 8'h30;
    cmd_wdata  = 32'hCAFEF00D;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("pre_reset_penable", PENABLE, 1'b1);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    chk("post_reset_cmd_ready", cmd_ready, 1'b1);
    chk("post_reset_psel", PSEL, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("post_reset_no_rsp", rsp_valid, 1'b0);
      step();
    end

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      wr = (written.size() == 0) || ($urandom_range(0, 1) == 1);
      addr = wr ? AW'($urandom) : written[$urandom_range(0, written.size() - 1)];
      r = $urandom_range(0, 9);
      waits = (r < 7) ? $urandom_range(0, 3) : ((r < 9) ? $urandom_range(4, 8)
                                                          : $urandom_range(14, 18));
      if (wr && waits < TO) written.push_back(addr);
      do_txn(wr, addr, $urandom, waits, lat);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the width of the PADDR and cmd_addr ports.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the PWDATA, PRDATA, cmd_wdata and rsp_rdata ports.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of ACCESS wait cycles; a value of 0 disables the timeout.
REQ-004 The block SHALL have port PCLK, input, 1 bit, the single clock.
REQ-005 The block SHALL have port PRESET, input, 1 bit, a synchronous, active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit, meaning a local request is present.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit, meaning the master can accept a request.
REQ-008 The block SHALL have port cmd_write, input, 1 bit, where 1 selects a write and 0 selects a read.
REQ-009 The block SHALL have port cmd_addr, input, ADDR_WIDTH bits, the request address.
REQ-010 The block SHALL have port cmd_wdata, input, DATA_WIDTH bits, the write data.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit, a one-cycle pulse marking transfer completion.
REQ-012 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits, the read data.
REQ-013 The block SHALL have port rsp_err, output, 1 bit, meaning the transfer was terminated by timeout.
REQ-014 The block SHALL have port PSEL, output, 1 bit, the APB select.
REQ-015 The block SHALL have port PENABLE, output, 1 bit, the APB enable.
REQ-016 The block SHALL have port PWRITE, output, 1 bit, the APB direction.
REQ-017 The block SHALL have port PADDR, output, ADDR_WIDTH bits, the APB address.
REQ-018 The block SHALL have port PWDATA, output, DATA_WIDTH bits, the APB write data.
REQ-019 The block SHALL have port PREADY, input, 1 bit, the slave ready.
REQ-020 The block SHALL have port PRDATA, input, DATA_WIDTH bits, the slave read data.

Function
REQ-021 The FSM SHALL have the states IDLE, SETUP and ACCESS, and any other encoding SHALL go to IDLE on the next cycle with all outputs driven to 0.
REQ-022 cmd_ready SHALL be 1 only in IDLE, and a request SHALL be accepted when cmd_valid and cmd_ready are both 1 at a PCLK edge, with cmd inputs ignored otherwise.
REQ-023 On acceptance, the block SHALL register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA and move to SETUP.
REQ-024 In SETUP the block SHALL drive PSEL=1 and PENABLE=0 for exactly one cycle, then move to ACCESS.
REQ-025 In ACCESS the block SHALL drive PSEL=1 and PENABLE=1, and PADDR, PWRITE and PWDATA SHALL remain unchanged from SETUP until the transfer ends.
REQ-026 When PREADY=1 is sampled in ACCESS, the block SHALL return to IDLE on the next cycle, drive PSEL=0 and PENABLE=0, pulse rsp_valid=1 with rsp_err=0, and set rsp_rdata to PRDATA for a read or to 0 for a write.
REQ-027 If PREADY is 1 in the first ACCESS cycle, the transfer SHALL take 3 cycles: acceptance at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, and rsp_valid and cmd_ready both 1 in cycle N+3.
REQ-028 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0, saturating at TIMEOUT.
REQ-029 When TIMEOUT is non-zero and the counter reaches TIMEOUT while PREADY is still 0, the block SHALL end the transfer the same way as on PREADY (IDLE, PSEL and PENABLE low) but with rsp_err=1 and rsp_rdata=0.
REQ-030 If PREADY=1 arrives in the same cycle that the timeout is reached, PREADY SHALL take priority and rsp_err SHALL be 0.
REQ-031 Outside completion cycles, rsp_valid SHALL be 0, rsp_rdata and rsp_err SHALL hold their last values, and PADDR, PWRITE and PWDATA SHALL hold their last values while in IDLE.
REQ-032 The block SHALL be limited to one outstanding transfer, so back-to-back transfers are separated by at least one IDLE cycle.

Reset
REQ-033 While PRESET=1 at a PCLK edge, the state SHALL be IDLE, the wait counter SHALL be 0, and every output except cmd_ready SHALL be 0.
REQ-034 A reset asserted during SETUP or ACCESS SHALL abort the transfer with no rsp_valid pulse, and cmd_ready SHALL be 1 in the first cycle after PRESET falls.

Structure
REQ-035 Package apb_pkg SHALL hold the state typedef (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the default width constants, and SHALL be shared with the slave.
REQ-036 The wait counter SHALL be the single sub-module apb_wait_timer, with inputs clear, enable and timeout and output expired.

Verification
REQ-037 Zero-wait write: a write of cmd_addr=0x10 with cmd_wdata=0xDEADBEEF SHALL give SETUP and ACCESS on consecutive cycles, rsp_valid 3 cycles after acceptance, and the slave memory at 0x10 SHALL equal 0xDEADBEEF.
REQ-038 Read-back: a read of 0x10 after that write SHALL give rsp_rdata=0xDEADBEEF with rsp_err=0.
REQ-039 Wait states: holding PREADY low for 4 ACCESS cycles SHALL keep PADDR and PWDATA stable throughout, with rsp_valid 7 cycles after acceptance.
REQ-040 Timeout: with TIMEOUT=16 and PREADY held at 0, rsp_err SHALL be 1 and rsp_rdata SHALL be 0, and PSEL SHALL fall after 16 ACCESS cycles.
REQ-041 Timeout tie: PREADY=1 in the cycle the counter reaches 16 SHALL give rsp_err=0 with valid data.
REQ-042 Reset mid-ACCESS: asserting PRESET for 1 cycle SHALL give PSEL=0 and no rsp_valid pulse, and cmd_ready SHALL be 1 in the first cycle after PRESET falls.
